// File: rtl/wb_stage.sv
// wb_stage: MEM/WB pipeline register and write-back logic for the P4
// pipelined MIPS core.
//
// The stage captures the MEM-stage result on each edge. It decodes the held
// instruction and selects the write-back data, including extraction and
// extension of load bytes and halfwords. It drives the register-file write
// port one cycle after capture.
//
// Ports:
//   clk        system clock, all state updates on posedge
//   reset      synchronous active-high, clears the stage to a bubble
//   stall      hold current contents
//   flush      load a bubble on the next edge
//   m_valid    MEM stage holds a real instruction
//   m_pc       PC of the MEM-stage instruction
//   m_instr    instruction word
//   m_alu      ALU result / load effective address
//   m_rdata    aligned data-memory word at {m_alu[31:2],2'b00}
//   grf_a3     destination register number
//   grf_wd     write data
//   grf_we     write enable
//   grf_pc     PC of the writing instruction
//   w_valid    stage holds a real instruction (hazard unit)
//   align_err  held load is misaligned, write suppressed
module wb_stage #(
  parameter logic [31:0] PC_RESET = 32'h0000_3000,
  parameter logic [4:0]  RA_REG   = 5'd31
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic        m_valid,
  input  logic [31:0] m_pc,
  input  logic [31:0] m_instr,
  input  logic [31:0] m_alu,
  input  logic [31:0] m_rdata,
  output logic [4:0]  grf_a3,
  output logic [31:0] grf_wd,
  output logic        grf_we,
  output logic [31:0] grf_pc,
  output logic        w_valid,
  output logic        align_err
);

  // Little-endian byte pick, sign- or zero-extended to 32 bits.
  function automatic logic [31:0] ext_byte(input logic [31:0] word,
                                           input logic [1:0]  ofs,
                                           input logic        sgn);
    logic [7:0]        b;
    logic signed [7:0] sb;
    case (ofs)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    sb = b;
    return sgn ? 32'(sb) : {24'd0, b};
  endfunction

  // Halfword pick selected by address bit 1, sign- or zero-extended.
  function automatic logic [31:0] ext_half(input logic [31:0] word,
                                           input logic        hi,
                                           input logic        sgn);
    logic [15:0]        h;
    logic signed [15:0] sh;
    h  = hi ? word[31:16] : word[15:0];
    sh = h;
    return sgn ? 32'(sh) : {16'd0, h};
  endfunction

  logic        vld_p1;
  logic [31:0] pc_p1;
  logic [31:0] instr_p1;
  logic [31:0] alu_p1;
  logic [31:0] rdata_p1;

  // MEM -> WB boundary
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      vld_p1   <= 1'b0;
      pc_p1    <= PC_RESET;
      instr_p1 <= 32'd0;
      alu_p1   <= 32'd0;
      rdata_p1 <= 32'd0;
    end else if (!stall) begin
      vld_p1   <= m_valid;
      pc_p1    <= m_pc;
      instr_p1 <= m_instr;
      alu_p1   <= m_alu;
      rdata_p1 <= m_rdata;
    end
  end

  logic [5:0]  op;
  logic [5:0]  fn;
  logic [4:0]  rd;
  logic [4:0]  rt;
  logic [1:0]  ofs;
  logic [31:0] link;
  logic        writing;
  logic        misalign;
  logic [4:0]  a3;
  logic [31:0] wd;

  assign op   = instr_p1[31:26];
  assign fn   = instr_p1[5:0];
  assign rd   = instr_p1[15:11];
  assign rt   = instr_p1[20:16];
  assign ofs  = alu_p1[1:0];
  assign link = pc_p1 + 32'd8;

  always_comb begin
    writing  = 1'b0;
    misalign = 1'b0;
    a3       = 5'd0;
    wd       = 32'd0;
    case (op)
      6'h00: begin
        if (fn == 6'h21 || fn == 6'h23) begin
          writing = 1'b1;
          a3      = rd;
          wd      = alu_p1;
        end else if (fn == 6'h09) begin
          writing = 1'b1;
          a3      = rd;
          wd      = link;
        end
      end
      6'h0D, 6'h0F: begin
        writing = 1'b1;
        a3      = rt;
        wd      = alu_p1;
      end
      6'h03: begin
        writing = 1'b1;
        a3      = RA_REG;
        wd      = link;
      end
      6'h23: begin
        writing  = 1'b1;
        a3       = rt;
        wd       = rdata_p1;
        misalign = (ofs != 2'd0);
      end
      6'h20, 6'h24: begin
        writing = 1'b1;
        a3      = rt;
        wd      = ext_byte(rdata_p1, ofs, op == 6'h20);
      end
      6'h21, 6'h25: begin
        writing  = 1'b1;
        a3       = rt;
        wd       = ext_half(rdata_p1, ofs[1], op == 6'h21);
        misalign = ofs[0];
      end
      default: ;
    endcase
  end

  // Bubbles present a zero destination and data so the hazard unit and the
  // register-file log never see stale decode results.
  assign grf_a3    = vld_p1 ? a3 : 5'd0;
  assign grf_wd    = vld_p1 ? wd : 32'd0;
  assign align_err = vld_p1 & misalign;
  assign grf_we    = vld_p1 & writing & (a3 != 5'd0) & ~misalign;
  assign grf_pc    = pc_p1;
  assign w_valid   = vld_p1;

endmodule

// File: tb/tb_wb_stage.sv
module tb_wb_stage;

  localparam logic [31:0] PC_RESET = 32'h0000_3000;

  logic        clk = 1'b0;
  logic        reset, stall, flush, m_valid;
  logic [31:0] m_pc, m_instr, m_alu, m_rdata;
  logic [4:0]  grf_a3;
  logic [31:0] grf_wd, grf_pc;
  logic        grf_we, w_valid, align_err;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  wb_stage #(.PC_RESET(PC_RESET), .RA_REG(5'd31)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .m_valid(m_valid), .m_pc(m_pc), .m_instr(m_instr), .m_alu(m_alu),
    .m_rdata(m_rdata), .grf_a3(grf_a3), .grf_wd(grf_wd), .grf_we(grf_we),
    .grf_pc(grf_pc), .w_valid(w_valid), .align_err(align_err)
  );

  always #5 clk = ~clk;

  // Reference state: what the stage should be holding.
  logic        mv;
  logic [31:0] mpc, mins, malu, mrd;

  always @(posedge clk) begin
    if (reset || flush) begin
      mv <= 1'b0; mpc <= PC_RESET; mins <= '0; malu <= '0; mrd <= '0;
    end else if (!stall) begin
      mv <= m_valid; mpc <= m_pc; mins <= m_instr; malu <= m_alu; mrd <= m_rdata;
    end
  end

  // Expected outputs from the held state, computed with shifts and masks.
  task automatic model_eval(output logic [4:0] a3, output logic [31:0] wd,
                            output logic we, output logic ae);
    logic [5:0]  op, fn;
    logic [31:0] b, h;
    logic        wr, mis;
    op = mins[31:26]; fn = mins[5:0];
    a3 = 5'd0; wd = 32'd0; wr = 1'b0; mis = 1'b0;
    b = (mrd >> (8 * int'(malu[1:0]))) & 32'hFF;
    h = (mrd >> (16 * int'(malu[1]))) & 32'hFFFF;
    if (op == 6'h00 && (fn == 6'h21 || fn == 6'h23)) begin
      wr = 1'b1; a3 = mins[15:11]; wd = malu;
    end else if (op == 6'h00 && fn == 6'h09) begin
      wr = 1'b1; a3 = mins[15:11]; wd = mpc + 32'd8;
    end else if (op == 6'h0D || op == 6'h0F) begin
      wr = 1'b1; a3 = mins[20:16]; wd = malu;
    end else if (op == 6'h03) begin
      wr = 1'b1; a3 = 5'd31; wd = mpc + 32'd8;
    end else if (op == 6'h23) begin
      wr = 1'b1; a3 = mins[20:16]; wd = mrd; mis = (malu[1:0] != 2'd0);
    end else if (op == 6'h20) begin
      wr = 1'b1; a3 = mins[20:16]; wd = b[7] ? (b | 32'hFFFF_FF00) : b;
    end else if (op == 6'h24) begin
      wr = 1'b1; a3 = mins[20:16]; wd = b;
    end else if (op == 6'h21) begin
      wr = 1'b1; a3 = mins[20:16]; wd = h[15] ? (h | 32'hFFFF_0000) : h;
      mis = malu[0];
    end else if (op == 6'h25) begin
      wr = 1'b1; a3 = mins[20:16]; wd = h; mis = malu[0];
    end
    if (!mv) begin a3 = 5'd0; wd = 32'd0; end
    ae = mv & mis;
    we = mv & wr & (a3 != 5'd0) & ~mis;
  endtask

  // Every-cycle comparison against the reference.
  always @(negedge clk) begin
    logic [4:0]  ea3;
    logic [31:0] ewd;
    logic        ewe, eae;
    if (chk_en) begin
      model_eval(ea3, ewd, ewe, eae);
      tests++;
      if (grf_a3 !== ea3 || grf_wd !== ewd || grf_we !== ewe || align_err !== eae ||
          grf_pc !== mpc || w_valid !== mv) begin
        fails++;
        $display("FAIL cycle_cmp t=%0t got a3=%0d wd=%h we=%b ae=%b pc=%h v=%b exp a3=%0d wd=%h we=%b ae=%b pc=%h v=%b",
                 $time, grf_a3, grf_wd, grf_we, align_err, grf_pc, w_valid,
                 ea3, ewd, ewe, eae, mpc, mv);
      end
    end
  end

  task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  // Pin both DUT and reference to a hand-computed value.
  task automatic lit_wd(input string name, input logic [31:0] exp);
    logic [4:0]  a3; logic [31:0] wd; logic we, ae;
    model_eval(a3, wd, we, ae);
    lit(name, grf_wd, exp);
    lit({"model_", name}, wd, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                       input logic [31:0] alu, input logic [31:0] rd);
    m_valid = v; m_pc = pc; m_instr = ins; m_alu = alu; m_rdata = rd;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [4:0] rs, rt, rd;
    logic [15:0] imm;
    rs = 5'($urandom); rt = 5'($urandom); rd = 5'($urandom); imm = 16'($urandom);
    case ($urandom_range(0, 13))
      0:  return {6'h00, rs, rt, rd, 5'd0, 6'h21};
      1:  return {6'h00, rs, rt, rd, 5'd0, 6'h23};
      2:  return {6'h00, rs, 5'd0, rd, 5'd0, 6'h09};
      3:  return {6'h0D, rs, rt, imm};
      4:  return {6'h0F, 5'd0, rt, imm};
      5:  return {6'h03, 26'($urandom)};
      6:  return {6'h23, rs, rt, imm};
      7:  return {6'h20, rs, rt, imm};
      8:  return {6'h24, rs, rt, imm};
      9:  return {6'h21, rs, rt, imm};
      10: return {6'h25, rs, rt, imm};
      11: return {6'h2B, rs, rt, imm};
      12: return {6'h04, rs, rt, imm};
      default: return $urandom;
    endcase
  endfunction

  initial begin
    reset = 1'b1; stall = 1'b0; flush = 1'b0;
    drive(1'b1, 32'hDEAD_BEEF, 32'h0022_1821, 32'h1234_5678, 32'hCAFE_F00D);
    @(negedge clk);
    cyc();
    chk_en = 1'b1;
    lit("rst_we", 32'(grf_we), 32'd0);
    lit("rst_a3", 32'(grf_a3), 32'd0);
    lit("rst_wd", grf_wd, 32'd0);
    lit("rst_pc", grf_pc, 32'h3000);
    lit("rst_valid", 32'(w_valid), 32'd0);
    lit("rst_aerr", 32'(align_err), 32'd0);

    reset = 1'b0;
    drive(1'b1, 32'h3004, 32'h0022_1821, 32'd5, 32'd0);
    cyc();
    lit("addu_we", 32'(grf_we), 32'd1);
    lit("addu_a3", 32'(grf_a3), 32'd3);
    lit_wd("addu_wd", 32'd5);
    lit("addu_pc", grf_pc, 32'h3004);

    drive(1'b1, 32'h3008, 32'h8004_0001, 32'd1, 32'h1234_80FF);
    cyc();
    lit_wd("lb_wd", 32'hFFFF_FF80);
    lit("lb_a3", 32'(grf_a3), 32'd4);
    drive(1'b1, 32'h300C, 32'h9004_0001, 32'd1, 32'h1234_80FF);
    cyc();
    lit_wd("lbu_wd", 32'h0000_0080);

    drive(1'b1, 32'h3010, 32'h8404_0003, 32'd3, 32'h1234_5678);
    cyc();
    lit("lh_mis_aerr", 32'(align_err), 32'd1);
    lit("lh_mis_we", 32'(grf_we), 32'd0);
    drive(1'b1, 32'h3014, 32'h9404_0002, 32'd2, 32'hABCD_0000);
    cyc();
    lit_wd("lhu_wd", 32'h0000_ABCD);
    lit("lhu_aerr", 32'(align_err), 32'd0);

    drive(1'b1, 32'h3010, 32'h0C00_0C00, 32'd0, 32'd0);
    cyc();
    lit("jal_a3", 32'(grf_a3), 32'd31);
    lit_wd("jal_wd", 32'h3018);
    lit("jal_we", 32'(grf_we), 32'd1);

    drive(1'b1, 32'hFFFF_FFFC, 32'h0C00_0000, 32'd0, 32'd0);
    cyc();
    lit_wd("jal_wrap_wd", 32'h0000_0004);

    drive(1'b1, 32'h3020, 32'h3405_0007, 32'd7, 32'd0);
    cyc();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, $urandom, rand_instr(), $urandom, $urandom);
      cyc();
      lit("stall_we", 32'(grf_we), 32'd1);
      lit("stall_a3", 32'(grf_a3), 32'd5);
      lit("stall_pc", grf_pc, 32'h3020);
      lit_wd("stall_wd", 32'd7);
    end
    flush = 1'b1;
    cyc();
    lit("flush_valid", 32'(w_valid), 32'd0);
    lit("flush_pc", grf_pc, 32'h3000);
    flush = 1'b0; stall = 1'b0;
    drive(1'b1, 32'h3024, 32'h3400_0007, 32'd7, 32'd0);
    cyc();
    lit("ori0_we", 32'(grf_we), 32'd0);
    lit("ori0_valid", 32'(w_valid), 32'd1);

    stall = 1'b1; reset = 1'b1;
    cyc();
    lit("rst_stall_valid", 32'(w_valid), 32'd0);
    stall = 1'b0; reset = 1'b0;

    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 99) == 0);
      flush = ($urandom_range(0, 99) < 5);
      stall = ($urandom_range(0, 99) < 15);
      drive($urandom_range(0, 3) != 0,
            ($urandom_range(0, 19) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom,
            rand_instr(), $urandom, $urandom);
      cyc();
    end

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- MEM/WB pipeline register plus write-back logic for the P4 pipelined MIPS core.
- Captures the MEM-stage result each cycle and decodes the held instruction.
- Selects the write-back data, including load byte/half extraction and extension, and the destination register.
- Drives the register-file write port (A3, WD, WE, PC) one cycle after capture.
- Exports the destination and valid to the hazard/forwarding unit.

Parameters:
- PC_RESET, 32'h0000_3000, PC value held while the stage holds a bubble.
- RA_REG, 5'd31, destination register for jal.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-high; clears the stage to a bubble.
- stall  in  1  hold the current contents (no capture).
- flush  in  1  load a bubble on the next edge.
- m_valid  in  1  MEM stage holds a real instruction.
- m_pc  in  32  PC of the MEM-stage instruction.
- m_instr  in  32  instruction word.
- m_alu  in  32  ALU result; also the effective address for loads.
- m_rdata  in  32  aligned word read from data memory at {m_alu[31:2],2'b00}.
- grf_a3  out  5  destination register number.
- grf_wd  out  32  write data.
- grf_we  out  1  write enable.
- grf_pc  out  32  PC of the writing instruction, used by the register file's write log.
- w_valid  out  1  stage holds a real instruction, for hazard logic.
- align_err  out  1  held load is misaligned; its write is suppressed.

Behaviour:
- Registers: valid, pc, instr, alu, rdata.
- Update priority on posedge clk: reset > flush > stall > capture.
  - reset or flush: valid=0, pc=PC_RESET, instr=0, alu=0, rdata=0.
  - stall (no reset/flush): all registers hold.
  - otherwise: capture all m_* inputs.
- Reset mid-stall or mid-flush: reset wins. After reset all outputs = 0, except grf_pc = PC_RESET.
- All outputs are combinational from the registers. Latency: an instruction captured at edge N is written to the register file at edge N+1.
- Decode, op = instr[31:26], fn = instr[5:0]:
  - addu (0/21h), subu (0/23h): a3 = rd (instr[15:11]), wd = alu.
  - jalr (0/09h): a3 = rd, wd = pc+8.
  - ori (0Dh), lui (0Fh): a3 = rt (instr[20:16]), wd = alu.
  - jal (03h): a3 = RA_REG, wd = pc+8.
  - lw (23h), lb (20h), lbu (24h), lh (21h), lhu (25h): a3 = rt, wd from the load extractor below.
  - Any other encoding (sw, beq, j, nop, etc.) is non-writing: a3 = 0, wd = 0.
- Load extractor, little-endian, o = alu[1:0]:
  - lb/lbu: byte = rdata[8*o+7 : 8*o]; lb sign-extends, lbu zero-extends.
  - lh/lhu: half = rdata[16*o[1]+15 : 16*o[1]]; lh sign-extends, lhu zero-extends.
  - lw: wd = rdata.
- Misalignment:
  - Misaligned load: lh/lhu with o[0]=1, or lw with o≠0.
  - For a misaligned load: align_err = valid; write suppressed.
- grf_we = valid & writing instruction & (a3 ≠ 0) & ~align_err.
- grf_a3 and grf_wd show the decoded values whenever valid=1, even if the write is suppressed. When valid=0 both are 0.
- grf_pc = pc register; w_valid = valid.
- Stall keeps grf_we asserted for the held instruction. The register file must tolerate a repeated identical write.
- pc+8 is computed modulo 2^32.

Test Plan:
1. Reset: assert reset for 2 cycles with garbage on the m_* inputs -> grf_we=0, grf_a3=0, grf_wd=0, grf_pc=3000h, w_valid=0, align_err=0.
2. addu $3,$1,$2 (instr 00221821h), m_alu=5, m_pc=3004h -> next cycle: grf_we=1, grf_a3=3, grf_wd=5, grf_pc=3004h.
3. lb $4,1($0) (80040001h), m_alu=1, m_rdata=1234_80FFh -> grf_wd=FFFF_FF80h, grf_a3=4. The same case as lbu (90040001h) -> grf_wd=0000_0080h.
4. lh with m_alu=3 -> align_err=1, grf_we=0. lhu with m_alu=2 and m_rdata=ABCD_0000h -> grf_wd=0000_ABCDh.
5. jal (0C000C00h) at m_pc=3010h -> grf_a3=31, grf_wd=3018h, grf_we=1.
6. Stall and flush:
   - Capture ori $5 at m_pc=3020h, then stall 3 cycles while the inputs change -> outputs constant (we=1, a3=5).
   - Assert flush and stall together -> bubble next cycle (w_valid=0).
   - ori $0 -> grf_we=0.
